// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Drives a registered one-hot grant, the mux select, and a valid flag.
module mux_rr_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       ptr, ptr_n;
  logic [3:0]       gnt_n;
  logic [1:0]       sel_n;
  logic             valid_n;

  // First set request after p in rotating order; p itself is checked last.
  // Returns {found, index}.
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] win_idle, win_rel;
  logic       release_c;

  assign win_idle  = pick(ptr, req);
  assign win_rel   = pick(sel, req);
  assign release_c = !req[sel] || (cnt == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      ptr   <= 2'd3;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      valid <= valid_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    valid_n = valid;
    cnt_n   = cnt;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        gnt_n   = '0;
        valid_n = 1'b0;
        if (en && (|req)) begin
          gnt_n   = 4'b0001 << win_idle[1:0];
          sel_n   = win_idle[1:0];
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!en) begin
          gnt_n   = '0;
          valid_n = 1'b0;
          cnt_n   = '0;
          ptr_n   = sel;
          state_n = IDLE;
        end else if (release_c) begin
          // Owner goes to the back of the order; hand over without a gap.
          ptr_n = sel;
          if (win_rel[2]) begin
            gnt_n   = 4'b0001 << win_rel[1:0];
            sel_n   = win_rel[1:0];
            valid_n = 1'b1;
            cnt_n   = CNT_W'(1);
          end else begin
            gnt_n   = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Randomized and directed bench for mux_rr_sel_arbiter against a
// transaction-level round-robin model.
module tb_mux_rr_sel_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: owner index (-1 when idle), last served index, hold count.
  int m_owner, m_ptr, m_hold, m_sel;

  mux_rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .sel(sel), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_hold  = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_edge(input logic e, input logic [3:0] r);
    int w;
    if (m_owner < 0) begin
      if (e && r != 4'b0) begin
        w = rr_pick(m_ptr, r);
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else if (!e) begin
      m_ptr = m_owner; m_owner = -1; m_hold = 0;
    end else if (!r[m_owner] || m_hold == MAX_HOLD) begin
      m_ptr = m_owner;
      w = rr_pick(m_ptr, r);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end else begin
      m_hold++;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
    chk({tag, ".cnt"}, 32'(dut.cnt), 32'(m_hold));
  endtask

  // Apply inputs, take one rising edge, compare just after it.
  task automatic step(input string tag, input logic e, input logic [3:0] r);
    en = e; req = r;
    @(posedge clk);
    model_edge(e, r);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0;
    model_reset();
    #2;
    check_all("t1_reset");
    #1 rst = 1'b0;

    // 1: first grant after reset
    step("t1_first", 1'b1, 4'b0001);
    chk("t1_gnt_const", 32'(gnt), 32'h1);

    // 2: full contention rotates every MAX_HOLD cycles
    do_reset("t2_rst");
    for (int i = 0; i < 20; i++) begin
      step("t2_rot", 1'b1, 4'b1111);
      chk("t2_gnt_const", 32'(gnt), 32'(4'b0001 << ((i / MAX_HOLD) % 4)));
    end

    // 3: sole requester re-granted at timeout with no gap
    do_reset("t3_rst");
    for (int i = 0; i < 10; i++) begin
      step("t3_sole", 1'b1, 4'b0100);
      chk("t3_cnt_const", 32'(dut.cnt), 32'((i % MAX_HOLD) + 1));
    end

    // 4: owner drops request
    do_reset("t4_rst");
    step("t4_a", 1'b1, 4'b0010);
    step("t4_b", 1'b1, 4'b1010);
    step("t4_c", 1'b1, 4'b1000);
    chk("t4_sel_const", 32'(sel), 32'h3);
    step("t4_d", 1'b1, 4'b0000);
    chk("t4_idle_sel", 32'(sel), 32'h3);

    // 5: pause and resume
    do_reset("t5_rst");
    step("t5_a", 1'b1, 4'b0001);
    step("t5_b", 1'b0, 4'b0001);
    step("t5_c", 1'b0, 4'b1111);
    step("t5_d", 1'b0, 4'b1111);
    step("t5_e", 1'b1, 4'b1111);
    chk("t5_gnt_const", 32'(gnt), 32'h2);

    // 6: async reset mid-grant
    do_reset("t6_rst");
    step("t6_a", 1'b1, 4'b0100);
    step("t6_b", 1'b1, 4'b0100);
    do_reset("t6_mid");
    step("t6_c", 1'b1, 4'b1100);
    chk("t6_gnt_const", 32'(gnt), 32'h4);

    // Random traffic with occasional pauses and resets
    for (int i = 0; i < 600; i++) begin
      logic       e;
      logic [3:0] r;
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: r = 4'b1111;
        1: r = 4'($urandom);
        2: r = 4'(1 << $urandom_range(0, 3));
        default: r = (m_owner >= 0 && $urandom_range(0, 1) == 1) ?
                     (req | 4'(1 << m_owner)) : 4'($urandom);
      endcase
      if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
      step("rnd", e, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
